sd_dac_out: RTL and testbench



---
 rtl/sd_dac_out_if.sv | 9 +
 rtl/sd_dac_out.sv | 135 +++++++++++++
 tb/tb_sd_dac_out.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dac_out_if.sv
// rtl/sd_dac_out_if.sv - sample handshake between the IIR chain and the DAC output stage
interface sd_dac_out_if;
    logic signed [17:0] sample_in;
    logic               sample_in_rdy;
    logic               sample_req;

    modport master (output sample_in, output sample_in_rdy, input sample_req);
    modport slave  (input sample_in, input sample_in_rdy, output sample_req);
endinterface

// File: rtl/sd_dac_out.sv
// rtl/sd_dac_out.sv - double-buffered sample stage and first-order sigma-delta DAC (optional SD_DAC_DITHER_EN)
module sd_dac_out #(
    parameter int unsigned SAMPLE_PERIOD = 1024
) (
    input  logic            clk,
    input  logic            reset,
    sd_dac_out_if.slave     sample_if,
    input  logic            underrun_clr,
    output logic            dac_out,
    output logic            underrun,
    output logic            overrun
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_PERIOD - 1);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t      state, state_nxt;
    logic [15:0] div_cnt;
    logic        sample_req;
    logic [17:0] active;
    logic [17:0] pending;
    logic        primed;
    logic [18:0] acc;
    logic [17:0] u;
    logic [17:0] u_acc;

    logic load_active, active_from_input, load_pending;
    logic set_underrun, set_overrun;

    wire tick = sample_req;
    wire rdy  = sample_if.sample_in_rdy;

    assign sample_if.sample_req = sample_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            sample_req <= 1'b0;
        end else begin
            div_cnt    <= (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
            sample_req <= (div_cnt == DIV_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    // A strobe coinciding with the tick never counts as overrun: the old pending moves out the same edge.
    always_comb begin
        state_nxt         = state;
        load_active       = 1'b0;
        active_from_input = 1'b0;
        load_pending      = 1'b0;
        set_underrun      = 1'b0;
        set_overrun       = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (tick) begin
                    if (rdy) begin
                        load_active       = 1'b1;
                        active_from_input = 1'b1;
                    end else if (primed) begin
                        set_underrun = 1'b1;
                    end
                end else if (rdy) begin
                    load_pending = 1'b1;
                    state_nxt    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (tick) begin
                    load_active = 1'b1;
                    if (rdy) load_pending = 1'b1;
                    else     state_nxt    = ST_EMPTY;
                end else if (rdy) begin
                    load_pending = 1'b1;
                    set_overrun  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active   <= '0;
            pending  <= '0;
            primed   <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load_active)
                active <= active_from_input ? sample_if.sample_in : pending;
            if (load_pending)
                pending <= sample_if.sample_in;
            if (rdy)
                primed <= 1'b1;
            underrun <= set_underrun | (underrun & ~underrun_clr);
            overrun  <= set_overrun  | (overrun  & ~underrun_clr);
        end
    end

    assign u = {~active[17], active[16:0]};

`ifdef SD_DAC_DITHER_EN
    logic [15:0]        lfsr;
    logic signed [19:0] u_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign u_sum = $signed({2'b00, u}) + $signed({{16{lfsr[3]}}, lfsr[3:0]});

    always_comb begin
        u_acc = u_sum[17:0];
        if (u_sum < 0)                 u_acc = 18'h00000;
        else if (u_sum > 20'sd262143)  u_acc = 18'h3FFFF;
    end
`else
    assign u_acc = u;
`endif

    // Carry out of the 18-bit phase is the bitstream; only reset clears the phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else       acc <= {1'b0, acc[17:0]} + {1'b0, u_acc};
    end

    assign dac_out = acc[18];

endmodule

// File: tb/tb_sd_dac_out.sv
// tb/tb_sd_dac_out.sv - directed self-checking bench for sd_dac_out
module tb_sd_dac_out;

    localparam int P = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic underrun_clr = 1'b0;
    logic dac_out, underrun, overrun;

    int n_checks = 0;
    int n_fails  = 0;

    sd_dac_out_if bus ();

    sd_dac_out #(.SAMPLE_PERIOD(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_if    (bus),
        .underrun_clr (underrun_clr),
        .dac_out      (dac_out),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.sample_in_rdy = 1'b0;
        bus.sample_in = '0;
        underrun_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (bus.sample_req !== 1'b1 && n < 4 * P) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic strobe(input logic [17:0] v);
        bus.sample_in = v;
        bus.sample_in_rdy = 1'b1;
        @(negedge clk);
        bus.sample_in_rdy = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] rv;
        do_reset();
        reset = 1'b1;
        #1;
        rv = {bus.sample_req, dac_out, underrun, overrun};
        n_checks++;
        if (rv !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_outputs: got %b expected 0000", rv);
        end
        n_checks++;
        if (dut.active !== 18'h0) begin
            n_fails++;
            $display("FAIL reset_active: got %h expected 00000", dut.active);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 3 * P; n++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sample_req !== ((n % P) == 0)) begin
                n_fails++;
                $display("FAIL idle_req n=%0d: got %b expected %b", n, bus.sample_req, (n % P) == 0);
            end
            n_checks++;
            if (dac_out !== ((n % 2) == 0)) begin
                n_fails++;
                $display("FAIL idle_dac n=%0d: got %b expected %b", n, dac_out, (n % 2) == 0);
            end
            n_checks++;
            if (underrun !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_underrun n=%0d: got %b expected 0", n, underrun);
            end
        end
    endtask

    task automatic test_full_scale();
        int ones;
        do_reset();
        strobe(18'h1FFFF);
        wait_tick();
        @(negedge clk);
        n_checks++;
        if (dut.active !== 18'h1FFFF) begin
            n_fails++;
            $display("FAIL fs_active: got %h expected 1ffff", dut.active);
        end
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (dac_out === 1'b1) ones++;
        end
        n_checks++;
        if (ones < 1023 || ones > 1024) begin
            n_fails++;
            $display("FAIL fs_density: got %0d ones expected 1023..1024", ones);
        end
        strobe(18'h20000);
        wait_tick();
        @(negedge clk);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dac_out !== 1'b0) ones++;
        end
        n_checks++;
        if (ones != 0) begin
            n_fails++;
            $display("FAIL neg_fs_density: got %0d ones expected 0", ones);
        end
    endtask

    task automatic test_underrun();
        int ones;
        do_reset();
        strobe(18'h10000);
        wait_tick();
        n_checks++;
        if (bus.sample_req !== 1'b1 || underrun !== 1'b0) begin
            n_fails++;
            $display("FAIL ur_tick1: req=%b underrun=%b expected req 1 underrun 0", bus.sample_req, underrun);
        end
        @(negedge clk);
        wait_tick();
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fails++;
            $display("FAIL ur_before_tick2: got %b expected 0", underrun);
        end
        @(negedge clk);
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fails++;
            $display("FAIL ur_after_tick2: got %b expected 1", underrun);
        end
        n_checks++;
        if (dut.active !== 18'h10000) begin
            n_fails++;
            $display("FAIL ur_active: got %h expected 10000", dut.active);
        end
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (dac_out === 1'b1) ones++;
        end
        n_checks++;
        if (ones != 768) begin
            n_fails++;
            $display("FAIL ur_density: got %0d ones expected 768", ones);
        end
        wait_tick();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fails++;
            $display("FAIL ur_set_wins: got %b expected 1", underrun);
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fails++;
            $display("FAIL ur_clear: got %b expected 0", underrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        strobe(18'h00100);
        strobe(18'h00200);
        n_checks++;
        if (overrun !== 1'b1 || dut.pending !== 18'h00200) begin
            n_fails++;
            $display("FAIL or_set: overrun=%b pending=%h expected 1 00200", overrun, dut.pending);
        end
        wait_tick();
        @(negedge clk);
        n_checks++;
        if (dut.active !== 18'h00200) begin
            n_fails++;
            $display("FAIL or_active: got %h expected 00200", dut.active);
        end
        n_checks++;
        if (overrun !== 1'b1 || underrun !== 1'b0) begin
            n_fails++;
            $display("FAIL or_sticky: overrun=%b underrun=%b expected 1 0", overrun, underrun);
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL or_clear: got %b expected 0", overrun);
        end
    endtask

    task automatic test_simultaneous();
        logic pv;
        do_reset();
        wait_tick();
        strobe(18'h3FFFF);
        pv = dut.state;
        n_checks++;
        if (dut.active !== 18'h3FFFF || pv !== 1'b0) begin
            n_fails++;
            $display("FAIL bypass: active=%h pend_valid=%b expected 3ffff 0", dut.active, pv);
        end
        n_checks++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL bypass_flags: underrun=%b overrun=%b expected 0 0", underrun, overrun);
        end
        strobe(18'h00005);
        wait_tick();
        strobe(18'h00007);
        pv = dut.state;
        n_checks++;
        if (dut.active !== 18'h00005 || dut.pending !== 18'h00007 || pv !== 1'b1) begin
            n_fails++;
            $display("FAIL tick_strobe: active=%h pending=%h pend_valid=%b expected 00005 00007 1",
                     dut.active, dut.pending, pv);
        end
        n_checks++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL tick_strobe_flags: underrun=%b overrun=%b expected 0 0", underrun, overrun);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] rv;
        logic pv;
        do_reset();
        strobe(18'h00111);
        strobe(18'h00222);
        wait_tick();
        rv = {bus.sample_req, overrun, 2'b00};
        n_checks++;
        if (rv !== 4'b1100) begin
            n_fails++;
            $display("FAIL ar_pre: req,overrun got %b expected 11", rv[3:2]);
        end
        reset = 1'b1;
        #1;
        rv = {bus.sample_req, dac_out, underrun, overrun};
        pv = dut.state;
        n_checks++;
        if (rv !== 4'b0000 || pv !== 1'b0 || dut.active !== 18'h0) begin
            n_fails++;
            $display("FAIL ar_immediate: outs=%b pend_valid=%b active=%h expected 0000 0 00000",
                     rv, pv, dut.active);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= P; n++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sample_req !== (n == P)) begin
                n_fails++;
                $display("FAIL ar_req n=%0d: got %b expected %b", n, bus.sample_req, n == P);
            end
        end
    endtask

    initial begin
        bus.sample_in = '0;
        bus.sample_in_rdy = 1'b0;
        test_reset();
        test_full_scale();
        test_underrun();
        test_overrun();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
